// File: rtl/arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Arbiter FSM states, transaction owner encoding and the watchdog abort data word.
// Imported by mem_port_arbiter and arb_watchdog.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Read data returned to the owner when a transaction is abandoned by the watchdog
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog for mem_port_arbiter (only built with ARB_TIMEOUT_EN).
// o_expire fires combinationally in the TIMEOUT-th busy cycle without i_ready.
// o_err is sticky until reset.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_expire,
  output logic o_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign o_expire = i_busy & ~i_ready & (r_cnt == CW'(TIMEOUT - 1));
  assign o_err    = r_err;

  // Count consecutive busy cycles; restart whenever the arbiter leaves BUSY
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (i_busy && !o_expire) ? r_cnt + CW'(1) : '0;
      r_err <= r_err | o_expire;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory, one transaction at a time.
// Zero-wait memory: request in cycle t -> mem_req_o in t+1 -> valid_o pulse in t+2; each wait state adds one.
// Optional watchdog (macro ARB_TIMEOUT_EN) aborts a stuck transaction, returns TIMEOUT_DATA and sets err_o.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_valid_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
`ifdef ARB_TIMEOUT_EN
  output logic                err_o,
`endif
  output logic                stall_f_o,
  output logic                stall_m_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int BW = DATA_W / 8;

  state_t              r_state;
  logic [SW-1:0]       r_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BW-1:0]       r_mem_be;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_d_valid;

  logic                w_if_elig;
  logic                w_d_elig;
  logic                w_grant_vld;
  owner_t              w_grant_own;
  logic                w_busy;
  logic                w_expire;

  assign w_busy = (r_state != IDLE);

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_busy   (w_busy),
    .i_ready  (mem_ready_i),
    .o_expire (w_expire),
    .o_err    (err_o)
  );
`else
  // Watchdog compiled out: a transaction waits for mem_ready_i indefinitely
  assign w_expire = (TIMEOUT < 0);
`endif

  // Eligibility excludes a requester whose completion pulse is showing, so a stale req is not re-granted
  always_comb begin
    w_if_elig   = if_req_i & ~r_if_valid;
    w_d_elig    = d_req_i & ~r_d_valid;
    w_grant_vld = (r_state == IDLE) & (w_if_elig | w_d_elig);
    w_grant_own = (w_d_elig && ((r_streak < SW'(MAX_D_STREAK)) || !w_if_elig)) ? OWN_D : OWN_I;
  end

  // Arbiter FSM: grant in IDLE, hold the memory request until ready (or watchdog), then pulse the owner's valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_mem_req <= 1'b1;
            if (w_grant_own == OWN_D) begin
              r_state     <= BUSY_D;
              r_mem_we    <= d_we_i;
              r_mem_addr  <= d_addr_i;
              r_mem_wdata <= d_wdata_i;
              r_mem_be    <= d_be_i;
              // Streak only grows while fetch is actually being starved
              if (!w_if_elig)
                r_streak <= '0;
              else if (r_streak != SW'(MAX_D_STREAK))
                r_streak <= r_streak + SW'(1);
            end else begin
              r_state     <= BUSY_I;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr_i;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
              r_streak    <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready_i) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (r_state == BUSY_I) begin
              r_if_rdata <= mem_rdata_i;
              r_if_valid <= 1'b1;
            end else begin
              // Stores leave the load data register untouched
              if (!r_mem_we)
                r_d_rdata <= mem_rdata_i;
              r_d_valid <= 1'b1;
            end
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (r_state == BUSY_I) begin
              r_if_rdata <= DATA_W'(TIMEOUT_DATA);
              r_if_valid <= 1'b1;
            end else begin
              r_d_rdata <= DATA_W'(TIMEOUT_DATA);
              r_d_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;
  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign d_rdata_o   = r_d_rdata;
  assign d_valid_o   = r_d_valid;
  assign stall_f_o   = if_req_i & ~r_if_valid;
  assign stall_m_o   = d_req_i & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requests/memory/reset.
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT = 8).
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        stall_f_o;
  logic        stall_m_o;
`ifdef ARB_TIMEOUT_EN
  logic        err_o;
`endif

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (MAXS),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_be_i      (d_be_i),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
`ifdef ARB_TIMEOUT_EN
    .err_o       (err_o),
`endif
    .stall_f_o   (stall_f_o),
    .stall_m_o   (stall_m_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the one outstanding transaction plus what each requester has seen
  bit          m_busy;
  bit          m_own_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  bit          m_ifv;
  bit          m_dv;
  logic [31:0] m_ifr;
  logic [31:0] m_dr;
  int          m_streak;
  int          m_wait;
  bit          m_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    m_ifv = 0; m_dv = 0; m_ifr = '0; m_dr = '0; m_streak = 0; m_wait = 0; m_err = 0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model over the coming edge
  task automatic tick();
    bit fe, de, nifv, ndv;
    #1;
    chk("mem_req", mem_req_o, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      if (m_own_d) begin
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("mem_be", mem_be_o, m_be);
      end
    end
    chk("if_valid", if_valid_o, m_ifv);
    chk("d_valid", d_valid_o, m_dv);
    chk("if_rdata", if_rdata_o, m_ifr);
    chk("d_rdata", d_rdata_o, m_dr);
    chk("stall_f", stall_f_o, if_req_i && !m_ifv);
    chk("stall_m", stall_m_o, d_req_i && !m_dv);
`ifdef ARB_TIMEOUT_EN
    chk("err", err_o, m_err);
`endif
    nifv = 0;
    ndv  = 0;
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      if (mem_ready_i) begin
        m_busy = 0;
        if (!m_own_d) begin
          m_ifr = mem_rdata_i; nifv = 1;
        end else begin
          if (!m_we) m_dr = mem_rdata_i;
          ndv = 1;
        end
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_wait + 1 == TO) begin
        m_busy = 0;
        m_err  = 1;
        if (m_own_d) begin m_dr = 32'hDEAD_BEEF; ndv = 1; end
        else begin m_ifr = 32'hDEAD_BEEF; nifv = 1; end
      end else begin
        m_wait++;
      end
`endif
    end else begin
      fe = if_req_i && !m_ifv;
      de = d_req_i && !m_dv;
      if (de && (m_streak < MAXS || !fe)) begin
        m_busy = 1; m_own_d = 1; m_wait = 0;
        m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_be = d_be_i;
        m_streak = fe ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (fe) begin
        m_busy = 1; m_own_d = 0; m_wait = 0;
        m_we = 0; m_addr = if_addr_i;
        m_streak = 0;
      end
    end
    m_ifv = nifv;
    m_dv  = ndv;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1; if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0;
    d_wdata_i = '0; d_be_i = '0; mem_rdata_i = '0; mem_ready_i = 0;
    repeat (3) @(negedge clk);
    #1;
    model_reset();

    // Reset state
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_d_valid", d_valid_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    reset = 0;
    tick();

    // Single fetch, zero wait states
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    tick();
    chk("f1_mem_req", mem_req_o, 1);
    chk("f1_mem_addr", mem_addr_o, 32'h0000_0010);
    mem_ready_i = 1; mem_rdata_i = 32'h0000_0513;
    tick();
    mem_ready_i = 0;
    chk("f1_if_valid", if_valid_o, 1);
    chk("f1_if_rdata", if_rdata_o, 32'h0000_0513);
    chk("f1_stall_f", stall_f_o, 0);
    if_req_i = 0;
    tick();
    chk("f1_pulse_end", if_valid_o, 0);

    // Simultaneous fetch and load, load served first with 2 wait states
    if_req_i = 1; if_addr_i = 32'h20; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; d_be_i = 4'hF;
    tick();
    chk("sim_first_addr", mem_addr_o, 32'h100);
    chk("sim_first_we", mem_we_o, 0);
    tick();
    tick();
    mem_ready_i = 1; mem_rdata_i = 32'hCAFE_0001;
    tick();
    chk("sim_d_valid", d_valid_o, 1);
    chk("sim_d_rdata", d_rdata_o, 32'hCAFE_0001);
    chk("sim_if_wait", stall_f_o, 1);
    d_req_i = 0; mem_ready_i = 0;
    tick();
    chk("sim_second_addr", mem_addr_o, 32'h20);
    mem_ready_i = 1; mem_rdata_i = 32'h1111_2222;
    tick();
    chk("sim_if_valid", if_valid_o, 1);
    chk("sim_if_rdata", if_rdata_o, 32'h1111_2222);
    if_req_i = 0; mem_ready_i = 0;
    tick();

    // Store with partial byte enables, one wait state
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h1234_5678; d_be_i = 4'b0011;
    tick();
    chk("st_we", mem_we_o, 1);
    chk("st_be", mem_be_o, 4'b0011);
    chk("st_wdata", mem_wdata_o, 32'h1234_5678);
    mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    chk("st_wdata_held", mem_wdata_o, 32'h1234_5678);
    mem_ready_i = 1;
    tick();
    chk("st_d_valid", d_valid_o, 1);
    chk("st_d_rdata_kept", d_rdata_o, 32'hCAFE_0001);
    d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
    tick();

    // Reset in the middle of a load, then a late ready
    d_req_i = 1; d_addr_i = 32'h300; d_be_i = 4'hF;
    tick();
    chk("rb_mem_req", mem_req_o, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rb_mem_req_cleared", mem_req_o, 0);
    d_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h5555_5555;
    tick();
    chk("rb_no_valid", d_valid_o, 0);
    chk("rb_still_idle", mem_req_o, 0);
    chk("rb_rdata_zero", d_rdata_o, 0);
    mem_ready_i = 0;
    tick();

    // Data streak: four data grants over a waiting fetch, then fetch forced
    for (int k = 0; k <= MAXS; k++) begin
      if_req_i = 1; if_addr_i = 32'h80; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400 + 32'(4 * k);
      tick();
      chk("streak_grant", mem_addr_o, (k < MAXS) ? (32'h400 + 32'(4 * k)) : 32'h80);
      if (k < MAXS) if_req_i = 0;
      else d_req_i = 0;
      mem_ready_i = 1; mem_rdata_i = $urandom;
      tick();
      if_req_i = 0; d_req_i = 0; mem_ready_i = 0;
      tick();
    end
    if_req_i = 1; if_addr_i = 32'h84; d_req_i = 1; d_addr_i = 32'h500;
    tick();
    chk("streak_cleared", mem_addr_o, 32'h500);
    if_req_i = 0; mem_ready_i = 1;
    tick();
    d_req_i = 0; mem_ready_i = 0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after TO busy cycles
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h600;
    tick();
    repeat (TO) tick();
    chk("to_d_valid", d_valid_o, 1);
    chk("to_d_rdata", d_rdata_o, 32'hDEAD_BEEF);
    chk("to_err", err_o, 1);
    d_req_i = 0;
    tick();
    chk("to_err_sticky", err_o, 1);
`endif

    // Randomized traffic, protocol-respecting except that an ungranted request may be withdrawn
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      mem_ready_i = ($urandom_range(0, 9) < 4);
      mem_rdata_i = $urandom;
      if (!(m_busy && !m_own_d)) begin
        if (if_req_i && !m_ifv) begin
          if ($urandom_range(0, 7) == 0) if_req_i = 0;
        end else begin
          if_req_i  = ($urandom_range(0, 2) == 0);
          if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (!(m_busy && m_own_d)) begin
        if (d_req_i && !m_dv) begin
          if ($urandom_range(0, 7) == 0) d_req_i = 0;
        end else begin
          d_req_i   = ($urandom_range(0, 2) == 0);
          d_we_i    = $urandom_range(0, 1);
          d_addr_i  = $urandom;
          d_wdata_i = $urandom;
          d_be_i    = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
